// File: rtl/im_fetch_arbiter_pkg.sv
// Shared constants for the instruction-memory fetch arbiter: default sizes,
// instruction opcodes and a small width helper.
package im_fetch_arbiter_pkg;

    localparam int unsigned NUM_C_DEF = 4;
    localparam int unsigned AW_DEF    = 16;
    localparam int unsigned DW_DEF    = 16;

    // Instruction opcodes. ENDOP marks the end of a core's program.
    localparam logic [15:0] NOP   = 16'd0;
    localparam logic [15:0] LDI   = 16'd1;
    localparam logic [15:0] LD    = 16'd2;
    localparam logic [15:0] ST    = 16'd3;
    localparam logic [15:0] ADD   = 16'd4;
    localparam logic [15:0] SUB   = 16'd5;
    localparam logic [15:0] MUL   = 16'd6;
    localparam logic [15:0] JMP   = 16'd7;
    localparam logic [15:0] JZ    = 16'd8;
    localparam logic [15:0] ENDOP = 16'd43;
    localparam logic [15:0] ADDM  = 16'd44;

    // Width of a core index; a single core still gets a 1-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/im_fetch_arbiter_if.sv
// Bundle of the per-core fetch handshake and the instruction-memory port.
// master: cores plus memory (drive requests and read data).
// slave:  the arbiter.
interface im_fetch_arbiter_if import im_fetch_arbiter_pkg::*; #(
    parameter int unsigned NUM_C = NUM_C_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF
) ();

    logic [NUM_C-1:0]    req;
    logic [NUM_C*AW-1:0] addr;
    logic [NUM_C-1:0]    gnt;
    logic [NUM_C-1:0]    rvalid;
    logic [NUM_C*DW-1:0] rdata;
    logic [NUM_C-1:0]    core_done;
    logic                all_done;
    logic                mem_en;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_rdata;

    modport master (
        output req, addr, mem_rdata,
        input  gnt, rvalid, rdata, core_done, all_done, mem_en, mem_addr
    );

    modport slave (
        input  req, addr, mem_rdata,
        output gnt, rvalid, rdata, core_done, all_done, mem_en, mem_addr
    );

endinterface

// File: rtl/im_fetch_arbiter_rr_pick.sv
// Round-robin picker: first eligible index at or above ptr, wrapping modulo NUM_C.
module rr_pick #(
    parameter int unsigned NUM_C = 4,
    parameter int unsigned PW    = 2
) (
    input  logic [NUM_C-1:0] eligible,
    input  logic [PW-1:0]    ptr,
    output logic [NUM_C-1:0] winner,
    output logic [PW-1:0]    win_idx,
    output logic             any
);

    // Scan NUM_C positions starting at ptr; the first hit wins.
    always_comb begin
        int unsigned j;
        winner  = '0;
        win_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < NUM_C; i++) begin
            j = 32'(ptr) + i;
            if (j >= NUM_C) begin
                j = j - NUM_C;
            end
            if (!any && eligible[j[PW-1:0]]) begin
                any                 = 1'b1;
                winner[j[PW-1:0]]   = 1'b1;
                win_idx             = j[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/im_fetch_arbiter.sv
// Shares one synchronous-read instruction memory among NUM_C cores.
// One grant per cycle, round-robin; response returns a fixed two edges later.
module im_fetch_arbiter import im_fetch_arbiter_pkg::*; #(
    parameter int unsigned NUM_C = NUM_C_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input logic              clk,
    input logic              rst_n,
    im_fetch_arbiter_if.slave bus
);

    localparam int unsigned PW = ptr_width(NUM_C);

    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NUM_C-1:0]    eligible;
    logic [NUM_C-1:0]    win_onehot;
    logic [PW-1:0]       win_idx;
    logic                win_any;

    logic [NUM_C-1:0]    gnt_q;
    logic [NUM_C-1:0]    rvalid_q;
    logic [NUM_C*DW-1:0] rdata_q;
    logic [NUM_C-1:0]    done_q;
    logic                all_done_q;
    logic                mem_en_q;
    logic [AW-1:0]       mem_addr_q;

    // Stage 1 tracks the cycle the address is at memory, stage 2 the cycle data returns.
    logic                s1_valid_q, s2_valid_q;
    logic [PW-1:0]       s1_id_q, s2_id_q;

    // Finished cores are never granted again.
    assign eligible = bus.req & ~done_q;

    rr_pick #(
        .NUM_C (NUM_C),
        .PW    (PW)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .winner   (win_onehot),
        .win_idx  (win_idx),
        .any      (win_any)
    );

    // Advance the pointer past the winner; hold it when nobody is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (win_any) begin
            ptr_d = (32'(win_idx) == NUM_C - 1) ? '0 : win_idx + 1'b1;
        end
    end

    // Grant, memory strobe, fetch pipeline and per-core completion state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            gnt_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            done_q     <= '0;
            all_done_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            gnt_q      <= win_onehot;
            mem_en_q   <= win_any;
            if (win_any) begin
                mem_addr_q <= bus.addr[win_idx*AW +: AW];
            end
            s1_valid_q <= win_any;
            s1_id_q    <= win_idx;
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
            rvalid_q   <= '0;
            if (s2_valid_q) begin
                rvalid_q[s2_id_q]             <= 1'b1;
                rdata_q[s2_id_q*DW +: DW]     <= bus.mem_rdata;
                if (bus.mem_rdata == DW'(ENDOP)) begin
                    done_q[s2_id_q] <= 1'b1;
                end
            end
            all_done_q <= &done_q;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.core_done = done_q;
    assign bus.all_done  = all_done_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_im_fetch_arbiter.sv
// Self-checking bench for im_fetch_arbiter: directed scenarios plus a randomized
// run compared cycle by cycle against a queue-based reference model.
module tb_im_fetch_arbiter;
    import im_fetch_arbiter_pkg::*;

    localparam int unsigned NC = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    im_fetch_arbiter_if #(.NUM_C(NC), .AW(AW), .DW(DW)) bus ();

    im_fetch_arbiter #(.NUM_C(NC), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction memory with a one-cycle synchronous read.
    logic [DW-1:0] ram [0:255];
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end

    int n_checks = 0;
    int n_fail = 0;
    int edge_n = 0;

    // Reference model state.
    typedef struct {
        int            due;
        int            core;
        logic [AW-1:0] a;
    } resp_t;
    resp_t               q[$];
    int                  m_ptr;
    logic [NC-1:0]       m_gnt, m_rv, m_done;
    logic                m_men, m_all;
    logic [AW-1:0]       m_maddr;
    logic [NC*DW-1:0]    m_rdata;

    // Advance model by one edge using the inputs currently driven, then clock the DUT.
    task automatic tick();
        int w;
        int c;
        logic all_prev;
        resp_t r;
        if (!rst_n) begin
            m_ptr = 0; m_done = '0; m_all = 1'b0; m_gnt = '0; m_rv = '0;
            m_men = 1'b0; m_maddr = '0; m_rdata = '0;
            q.delete();
        end else begin
            all_prev = &m_done;
            w = -1;
            for (int i = 0; i < NC; i++) begin
                c = (m_ptr + i) % NC;
                if (w < 0 && bus.req[c] && !m_done[c]) w = c;
            end
            m_gnt = '0; m_men = 1'b0; m_rv = '0;
            if (w >= 0) begin
                m_gnt[w] = 1'b1;
                m_men = 1'b1;
                m_maddr = bus.addr[w*AW +: AW];
                m_ptr = (w + 1) % NC;
                q.push_back('{due: edge_n + 2, core: w, a: m_maddr});
            end
            while (q.size() > 0 && q[0].due == edge_n) begin
                r = q.pop_front();
                m_rv[r.core] = 1'b1;
                m_rdata[r.core*DW +: DW] = ram[r.a[7:0]];
                if (ram[r.a[7:0]] == ENDOP) m_done[r.core] = 1'b1;
            end
            m_all = all_prev;
        end
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0;
        bus.addr = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = '1;
        bus.addr = {16'd1, 16'd2, 16'd3, 16'd4};
        tick();
        tick();
        n_checks++; if (bus.gnt !== '0) begin n_fail++;
            $display("FAIL reset_gnt got %b want 0", bus.gnt); end
        n_checks++; if (bus.rvalid !== '0) begin n_fail++;
            $display("FAIL reset_rvalid got %b want 0", bus.rvalid); end
        n_checks++; if (bus.rdata !== '0) begin n_fail++;
            $display("FAIL reset_rdata got %h want 0", bus.rdata); end
        n_checks++; if (bus.mem_en !== 1'b0) begin n_fail++;
            $display("FAIL reset_mem_en got %b want 0", bus.mem_en); end
        n_checks++; if (bus.mem_addr !== '0) begin n_fail++;
            $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        n_checks++; if (bus.core_done !== '0) begin n_fail++;
            $display("FAIL reset_core_done got %b want 0", bus.core_done); end
        n_checks++; if (bus.all_done !== 1'b0) begin n_fail++;
            $display("FAIL reset_all_done got %b want 0", bus.all_done); end
        bus.req = '0;
        rst_n = 1'b1;
    endtask

    // Core 2 alone fetches ram[5]=17.
    task automatic test_single_fetch();
        do_reset();
        ram[5] = 16'd17;
        bus.req = 4'b0100;
        bus.addr[2*AW +: AW] = 16'd5;
        tick();
        n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++;
            $display("FAIL single_gnt got %b want 0100", bus.gnt); end
        n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'd5) begin n_fail++;
            $display("FAIL single_mem got en=%b addr=%0d want en=1 addr=5",
                     bus.mem_en, bus.mem_addr); end
        bus.req = '0;
        tick();
        n_checks++; if (bus.gnt !== '0 || bus.rvalid !== '0 || bus.mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle got gnt=%b rv=%b en=%b want all 0",
                     bus.gnt, bus.rvalid, bus.mem_en); end
        n_checks++; if (bus.mem_addr !== 16'd5) begin n_fail++;
            $display("FAIL single_addr_hold got %0d want 5", bus.mem_addr); end
        tick();
        n_checks++; if (bus.rvalid !== 4'b0100) begin n_fail++;
            $display("FAIL single_rvalid got %b want 0100", bus.rvalid); end
        n_checks++; if (bus.rdata[2*DW +: DW] !== 16'd17) begin n_fail++;
            $display("FAIL single_rdata got %0d want 17", bus.rdata[2*DW +: DW]); end
        tick();
        n_checks++; if (bus.rvalid !== '0 || bus.rdata[2*DW +: DW] !== 16'd17) begin n_fail++;
            $display("FAIL single_hold got rv=%b rdata=%0d want rv=0 rdata=17",
                     bus.rvalid, bus.rdata[2*DW +: DW]); end
    endtask

    // All cores request continuously: 0,1,2,3,0,... with responses two edges later.
    task automatic test_round_robin();
        logic [NC-1:0] eg, ev;
        int k;
        do_reset();
        for (int c = 0; c < NC; c++) bus.addr[c*AW +: AW] = AW'(10 + c);
        bus.req = '1;
        for (int i = 0; i < 12; i++) begin
            tick();
            eg = '0; eg[i % NC] = 1'b1;
            n_checks++; if (bus.gnt !== eg) begin n_fail++;
                $display("FAIL rr_gnt cyc=%0d got %b want %b", i, bus.gnt, eg); end
            if (i >= 2) begin
                k = (i - 2) % NC;
                ev = '0; ev[k] = 1'b1;
                n_checks++; if (bus.rvalid !== ev || bus.rdata[k*DW +: DW] !== ram[10 + k])
                begin n_fail++;
                    $display("FAIL rr_resp cyc=%0d got rv=%b d=%0d want rv=%b d=%0d", i,
                             bus.rvalid, bus.rdata[k*DW +: DW], ev, ram[10 + k]); end
            end
        end
        bus.req = '0;
    endtask

    // With ptr at 3, cores 1 and 3 requesting: 3 first, then 1, pointer left at 2.
    task automatic test_ptr_wrap();
        do_reset();
        bus.req = 4'b0100;
        bus.addr[2*AW +: AW] = 16'd20;
        tick();
        n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++;
            $display("FAIL wrap_setup got %b want 0100", bus.gnt); end
        bus.req = 4'b1010;
        bus.addr[1*AW +: AW] = 16'd21;
        bus.addr[3*AW +: AW] = 16'd23;
        tick();
        n_checks++; if (bus.gnt !== 4'b1000) begin n_fail++;
            $display("FAIL wrap_first got %b want 1000", bus.gnt); end
        bus.req = 4'b0010;
        tick();
        n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++;
            $display("FAIL wrap_second got %b want 0010", bus.gnt); end
        bus.req = 4'b1111;
        tick();
        n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++;
            $display("FAIL wrap_ptr2 got %b want 0100", bus.gnt); end
        bus.req = '0;
    endtask

    // ENDOP fetches set core_done; in-flight fetches still finish; all_done follows.
    task automatic test_endop();
        bit eg[6] = '{1, 1, 1, 0, 0, 0};
        bit ev[6] = '{0, 0, 1, 1, 1, 0};
        bit ed[6] = '{0, 0, 1, 1, 1, 1};
        bit seen;
        do_reset();
        ram[40] = ENDOP;
        for (int c = 0; c < NC; c++) bus.addr[c*AW +: AW] = 16'd40;
        bus.req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (bus.gnt[0] !== eg[i] || bus.rvalid[0] !== ev[i] || bus.core_done[0] !== ed[i])
            begin n_fail++;
                $display("FAIL endop_c0 cyc=%0d got g=%b rv=%b d=%b want g=%b rv=%b d=%b", i,
                         bus.gnt[0], bus.rvalid[0], bus.core_done[0], eg[i], ev[i], ed[i]);
            end
        end
        bus.req = 4'b1111;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            n_checks++; if (bus.gnt[0] !== 1'b0) begin n_fail++;
                $display("FAIL endop_regrant cyc=%0d got %b want 0", i, bus.gnt[0]); end
            if (bus.core_done == 4'b1111) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++;
            $display("FAIL endop_timeout got core_done=%b want 1111", bus.core_done);
        end else if (bus.all_done !== 1'b0) begin n_fail++;
            $display("FAIL endop_all_early got %b want 0", bus.all_done);
        end
        tick();
        n_checks++; if (bus.all_done !== 1'b1) begin n_fail++;
            $display("FAIL endop_all_done got %b want 1", bus.all_done); end
        bus.req = '0;
        ram[40] = 16'd140;
    endtask

    // Reset one cycle after a grant drops the fetch and restarts the pointer.
    task automatic test_reset_midflight();
        int rv0;
        do_reset();
        bus.req = 4'b0010;
        bus.addr[1*AW +: AW] = 16'd7;
        tick();
        n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++;
            $display("FAIL midrst_gnt got %b want 0010", bus.gnt); end
        bus.req = '0;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (bus.gnt !== '0 || bus.rvalid !== '0 || bus.rdata !== '0 || bus.mem_en !== 1'b0 ||
            bus.mem_addr !== '0 || bus.core_done !== '0 || bus.all_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs got g=%b rv=%b d=%h en=%b a=%h cd=%b ad=%b want 0",
                     bus.gnt, bus.rvalid, bus.rdata, bus.mem_en, bus.mem_addr,
                     bus.core_done, bus.all_done);
        end
        rst_n = 1'b1;
        bus.req = 4'b0011;
        bus.addr[0*AW +: AW] = 16'd3;
        tick();
        n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++;
            $display("FAIL midrst_first got %b want 0001", bus.gnt); end
        bus.req = '0;
        rv0 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (bus.rvalid[1] !== 1'b0) begin n_fail++;
                $display("FAIL midrst_stale cyc=%0d got rvalid1=1 want 0", i); end
            if (bus.rvalid[0] === 1'b1) rv0++;
        end
        n_checks++; if (rv0 != 1) begin n_fail++;
            $display("FAIL midrst_rv0 got %0d pulses want 1", rv0); end
    endtask

    // Core 2 holds its request over three grants: three identical responses.
    task automatic test_back_to_back();
        int ng, nr;
        do_reset();
        ram[9] = 16'd123;
        bus.req = 4'b0100;
        bus.addr[2*AW +: AW] = 16'd9;
        ng = 0; nr = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.gnt[2] === 1'b1) ng++;
            if (ng == 3) bus.req = '0;
            if (bus.rvalid[2] === 1'b1) begin
                nr++;
                n_checks++; if (bus.rdata[2*DW +: DW] !== 16'd123) begin n_fail++;
                    $display("FAIL b2b_rdata got %0d want 123", bus.rdata[2*DW +: DW]); end
            end
        end
        n_checks++; if (ng != 3) begin n_fail++;
            $display("FAIL b2b_grants got %0d want 3", ng); end
        n_checks++; if (nr != 3) begin n_fail++;
            $display("FAIL b2b_responses got %0d want 3", nr); end
    endtask

    // Random requests (held until granted), occasional resets, full model compare.
    task automatic test_random();
        logic [NC-1:0] pend;
        do_reset();
        for (int a = 0; a < 32; a++) ram[a] = (a % 8 == 7) ? ENDOP : DW'($urandom_range(0, 999));
        pend = '0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NC; c++) begin
                if (!pend[c] && $urandom_range(0, 2) == 0) begin
                    pend[c] = 1'b1;
                    bus.addr[c*AW +: AW] = AW'($urandom_range(0, 31));
                end
            end
            rst_n = ($urandom_range(0, 99) != 0);
            if (!rst_n) pend = '0;
            bus.req = pend;
            tick();
            rst_n = 1'b1;
            pend = pend & ~m_gnt;
            n_checks++; if (bus.gnt !== m_gnt) begin n_fail++;
                $display("FAIL rand_gnt cyc=%0d got %b want %b", i, bus.gnt, m_gnt); end
            n_checks++; if (bus.mem_en !== m_men) begin n_fail++;
                $display("FAIL rand_mem_en cyc=%0d got %b want %b", i, bus.mem_en, m_men); end
            n_checks++; if (bus.mem_addr !== m_maddr) begin n_fail++;
                $display("FAIL rand_mem_addr cyc=%0d got %h want %h", i, bus.mem_addr, m_maddr);
            end
            n_checks++; if (bus.rvalid !== m_rv) begin n_fail++;
                $display("FAIL rand_rvalid cyc=%0d got %b want %b", i, bus.rvalid, m_rv); end
            n_checks++; if (bus.rdata !== m_rdata) begin n_fail++;
                $display("FAIL rand_rdata cyc=%0d got %h want %h", i, bus.rdata, m_rdata); end
            n_checks++; if (bus.core_done !== m_done) begin n_fail++;
                $display("FAIL rand_core_done cyc=%0d got %b want %b", i, bus.core_done, m_done);
            end
            n_checks++; if (bus.all_done !== m_all) begin n_fail++;
                $display("FAIL rand_all_done cyc=%0d got %b want %b", i, bus.all_done, m_all);
            end
        end
        bus.req = '0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ram[a] = DW'(a + 100);
        bus.req = '0;
        bus.addr = '0;
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_ptr_wrap();
        test_endop();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at edge %0d", edge_n);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/im_fetch_arbiter.md
IM_FETCH_ARBITER -- requirements
Module: im_fetch_arbiter

Interface
REQ-001 Parameter NUM_C, default `NUM_C from definitions.v, number of cores sharing the instruction memory.
REQ-002 Parameter AW, default 16, instruction address width per core.
REQ-003 Parameter DW, default 16, instruction word width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 req  input  NUM_C  per-core fetch request; held with addr until gnt.
REQ-007 addr  input  NUM_C*AW  per-core fetch address, core i at [i*AW +: AW].
REQ-008 gnt  output  NUM_C  registered one-hot, one-cycle grant pulse.
REQ-009 rvalid  output  NUM_C  registered one-cycle pulse, rdata slice for that core is valid.
REQ-010 rdata  output  NUM_C*DW  per-core fetched word, held until that core's next rvalid.
REQ-011 mem_en  output  1  registered, memory read strobe.
REQ-012 mem_addr  output  AW  registered, address to the single-read-port instruction memory.
REQ-013 mem_rdata  input  DW  memory output, valid one cycle after mem_addr/mem_en presented (synchronous read).
REQ-014 core_done  output  NUM_C  sticky flag, core fetched ENDOP.
REQ-015 all_done  output  1  registered AND of core_done.

Function
REQ-016 The eligible set SHALL be req & ~core_done, sampled at each rising edge.
REQ-017 Arbitration SHALL be round-robin: search from pointer ptr upward modulo NUM_C; first eligible index w wins.
REQ-018 On a grant, ptr SHALL become (w+1) mod NUM_C; with no eligible request ptr SHALL be unchanged.
REQ-019 At edge k with winner w: gnt[w]=1, mem_en=1, mem_addr=addr[w] for the following cycle; otherwise gnt=0, mem_en=0, mem_addr holds its last value.
REQ-020 The winner id SHALL traverse a two-stage valid/id pipeline; at edge k+2 rdata[w] <= mem_rdata and rvalid[w]=1 for one cycle.
REQ-021 Latency SHALL be fixed: request sampled at edge k, rvalid visible after edge k+2.
REQ-022 Throughput SHALL be one grant per cycle; back-to-back grants to different or same core are allowed.
REQ-023 req held high after gnt SHALL be treated as a new request (same addr re-fetched unless changed).
REQ-024 At most one gnt bit and one rvalid bit SHALL be set per cycle.
REQ-025 When the word captured for core w equals ENDOP (16'd43), core_done[w] SHALL set at the same edge as rvalid[w] and stay set until reset.
REQ-026 Requests in flight for a core when its core_done sets SHALL still complete with rvalid.
REQ-027 With NUM_C=1 the block SHALL degenerate to a 2-cycle fetch pipe with ptr fixed at 0.

Reset
REQ-028 When rst_n=0 at an edge: gnt=0, rvalid=0, rdata=0, mem_en=0, mem_addr=0, core_done=0, all_done=0, ptr=0, pipeline valids=0.
REQ-029 Reset mid-operation SHALL drop all in-flight fetches; no rvalid SHALL appear for them after reset release.
REQ-030 First grant SHALL be possible at the first edge with rst_n=1.

Structure
REQ-031 Opcode constants (NOP..ADDM, including ENDOP=43) and AW/DW defaults SHALL live in a shared package, replacing per-module parameter lists.
REQ-032 Round-robin selection SHALL be a sub-module rr_pick (inputs eligible, ptr; outputs one-hot winner, winner index, any).

Verification
REQ-033 NUM_C=4, only core 2 requests addr 5, ram[5]=17 -> gnt[2] after edge 1, mem_addr=5, rvalid[2] and rdata[2]=17 after edge 3.
REQ-034 All 4 cores request continuously from reset -> grants 0,1,2,3,0,... one per cycle, each core every 4th cycle.
REQ-035 ptr=3, cores 1 and 3 request -> core 3 granted first, then core 1, ptr ends at 2.
REQ-036 Core 0 fetches address holding 43 -> core_done[0]=1 with rvalid[0]; further req[0] never granted; all_done=1 one edge after last core fetches 43.
REQ-037 rst_n low for one edge one cycle after a grant to core 1 -> no rvalid[1] afterwards, all outputs 0, next grant goes to core 0 if requesting.
REQ-038 Core 2 holds req high with fixed addr across 3 of its grants -> 3 identical rvalid/rdata pulses, no missed or duplicated response.
